// File: rtl/instr_encoder.sv
// RV32I field-to-instruction encoder feeding a DEPTH-entry output FIFO; 1-cycle latency.
// in_ready drops when the FIFO is full (registered count only); illegal requests become NOP with out_err.
module instr_encoder #(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_immed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ir,
    output logic        out_err,
    output logic [7:0]  err_cnt
);
    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP_RG3 = 7'b0110011;
    localparam logic [6:0] OPC_SYS    = 7'b1110011;
    localparam logic [31:0] NOP_IR    = 32'h00000013;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_err_cnt;
    logic [32:0]   r_mem [DEPTH];

    logic          w_push;
    logic          w_pop;
    logic          w_legal;
    logic [31:0]   w_ir;
    logic [31:0]   w_enc_ir;
    logic          w_sx_i;
    logic          w_sx_b;
    logic          w_sx_j;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign err_cnt   = r_err_cnt;

    // Upper immediate bits must be pure sign extension of the encodable field.
    assign w_sx_i = (&in_immed[31:11]) | ~(|in_immed[31:11]);
    assign w_sx_b = (&in_immed[31:12]) | ~(|in_immed[31:12]);
    assign w_sx_j = (&in_immed[31:20]) | ~(|in_immed[31:20]);

    always_comb begin
        w_ir    = '0;
        w_legal = 1'b0;
        case (in_opcode)
            OPC_OP_RG3: begin
                w_ir    = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                w_legal = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYS: begin
                w_ir    = {in_immed[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                w_legal = w_sx_i;
            end
            OPC_STORE: begin
                w_ir    = {in_immed[11:5], in_rs2, in_rs1, in_funct3, in_immed[4:0], in_opcode};
                w_legal = w_sx_i;
            end
            OPC_BRANCH: begin
                w_ir    = {in_immed[12], in_immed[10:5], in_rs2, in_rs1, in_funct3,
                           in_immed[4:1], in_immed[11], in_opcode};
                w_legal = w_sx_b && !in_immed[0];
            end
            OPC_LUI, OPC_AUIPC: begin
                w_ir    = {in_immed[31:12], in_rd, in_opcode};
                w_legal = ~(|in_immed[11:0]);
            end
            OPC_JAL: begin
                w_ir    = {in_immed[20], in_immed[10:1], in_immed[11], in_immed[19:12],
                           in_rd, in_opcode};
                w_legal = w_sx_j && !in_immed[0];
            end
            default: begin
                w_ir    = '0;
                w_legal = 1'b0;
            end
        endcase
    end

    assign w_enc_ir = w_legal ? w_ir : NOP_IR;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= wrap_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= wrap_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && !w_legal && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (!RST && w_push) begin
            r_mem[r_wr_ptr] <= {~w_legal, w_enc_ir};
        end
    end

    assign {out_err, out_ir} = out_valid ? r_mem[r_rd_ptr] : 33'd0;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver queues hand-computed encodings, negedge monitor pops and compares.
module tb_instr_encoder;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] AUIPC  = 7'h17;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] JALR   = 7'h67;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] LOAD   = 7'h03;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] OP_RG3 = 7'h33;
    localparam logic [6:0] SYS    = 7'h73;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_immed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic        out_err;
    logic [7:0]  err_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pops   = 0;
    logic [7:0]  exp_errcnt = 8'd0;
    logic [32:0] sb [$];
    logic [32:0] exp_e;

    instr_encoder #(.DEPTH(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_immed  (in_immed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ir    (out_ir),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Monitor: compares each popped head against the scoreboard; idle outputs must read zero.
    always @(negedge CLK) begin
        if (!RST) begin
            if (out_valid && out_ready) begin
                n_pops++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, required no output", {out_err, out_ir});
                end else begin
                    exp_e = sb.pop_front();
                    chk("out_entry", {31'd0, out_err, out_ir}, {31'd0, exp_e});
                end
            end else if (!out_valid) begin
                chk("idle_out_zero", {31'd0, out_err, out_ir}, 64'd0);
            end
        end
    end

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic [31:0] eir, input logic eerr);
        bit done;
        done      = 1'b0;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_immed  = imm;
        in_valid  = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (in_ready) begin
                sb.push_back({eerr, eir});
                if (eerr && exp_errcnt != 8'hFF) exp_errcnt++;
                done = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1");
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (sb.size() != 0 || out_valid); i++) begin
            @(posedge CLK);
            #1;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int pops0;
        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_immed = '0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ir",    64'(out_ir),    64'd0);
        chk("rst_out_err",   64'(out_err),   64'd0);
        chk("rst_err_cnt",   64'(err_cnt),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // addi x1, x0, 5 -- output must be present the cycle after acceptance
        out_ready = 1'b1;
        send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
        chk("lat1_valid", 64'(out_valid), 64'd1);
        chk("lat1_ir",    64'(out_ir),    64'h00500093);

        send(STORE,  5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'hFFFFFFFC, 32'hFE21AE23, 1'b0);
        send(JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,        32'h008000EF, 1'b0);
        send(LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
        send(OP_RG3, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0000DEAD, 32'h402081B3, 1'b0);
        send(BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFF8, 32'hFE208CE3, 1'b0);
        send(JALR,   5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0,        32'h00008067, 1'b0);
        send(LOAD,   5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFFFFFF, 32'hFFF12283, 1'b0);
        send(AUIPC,  5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000, 32'h00001097, 1'b0);
        send(SYS,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,        32'h00000073, 1'b0);

        send(BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, NOP, 1'b1);
        chk("err_cnt_first", 64'(err_cnt), 64'd1);

        send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, NOP, 1'b1);
        send(LUI,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000123, NOP, 1'b1);
        send(7'h7F,  5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,        NOP, 1'b1);
        send(JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        NOP, 1'b1);
        send(JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, NOP, 1'b1);
        send(STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFF7FF, NOP, 1'b1);
        chk("err_cnt_seven", 64'(err_cnt), 64'd7);
        drain();

        // Backpressure: two fill the FIFO, the third waits until the consumer resumes
        out_ready = 1'b0;
        fork
            begin
                send(OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h00100113, 1'b0);
                send(OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h00200193, 1'b0);
                send(OP_IMM, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00300213, 1'b0);
            end
            begin
                repeat (2) begin @(posedge CLK); #1; end
                chk("full_in_ready", 64'(in_ready), 64'd0);
                @(posedge CLK); #1;
                chk("held_in_ready", 64'(in_ready), 64'd0);
                chk("held_head_ir",  64'(out_ir),   64'h00100113);
                out_ready = 1'b1;
            end
        join
        drain();

        // Streaming: push and pop every cycle keeps one entry resident
        pops0 = n_pops;
        for (int i = 0; i < 8; i++) begin
            send(OP_IMM, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i),
                 {12'(i), 5'd0, 3'd0, 5'(i + 1), 7'h13}, 1'b0);
            if (i > 0) begin
                chk("stream_valid", 64'(out_valid), 64'd1);
                chk("stream_ready", 64'(in_ready),  64'd1);
            end
        end
        @(posedge CLK); #1;
        chk("stream_pops", 64'(n_pops - pops0), 64'd8);
        drain();

        for (int i = 0; i < 300; i++) begin
            send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, NOP, 1'b1);
        end
        chk("err_cnt_sat", 64'(err_cnt), 64'hFF);
        drain();

        // Mid-operation reset discards two buffered entries
        out_ready = 1'b0;
        send(OP_IMM, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 32'h00600313, 1'b0);
        send(OP_IMM, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h00700393, 1'b0);
        chk("prerst_in_ready", 64'(in_ready), 64'd0);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        sb.delete();
        exp_errcnt = 8'd0;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        chk("midrst_err_cnt",   64'(err_cnt),   64'd0);

        out_ready = 1'b1;
        send(LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
        drain();
        chk("final_err_cnt", 64'(err_cnt), 64'(exp_errcnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
